// File: rtl/reg_write_arbiter.sv
// Register-file write port shared by two requesters, with an optional
// post-reset sweep that writes each address 0..INIT_LAST with its own index.
module reg_write_arbiter #(
  parameter bit          INIT_EN   = 1'b1,
  parameter int unsigned INIT_LAST = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] addr0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [2:0] addr1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       write_reg,
  output logic [2:0] write_addr,
  output logic [7:0] write_data,
  output logic       init_done
);

  localparam int NUM_REQ = 2;
  localparam logic [2:0] LAST_K = 3'(INIT_LAST);

  typedef enum logic {S_INIT, S_ARB} state_t;
  localparam state_t RST_STATE = INIT_EN ? S_INIT : S_ARB;

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0][2:0] addr;
  logic [NUM_REQ-1:0][7:0] data;

  assign req  = {req1, req0};
  assign addr = {addr1, addr0};
  assign data = {data1, data0};

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               wr_q, wr_d;
  logic [2:0]         waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               done_q, done_d;
  logic [NUM_REQ-1:0] elig;
  logic               win;

  // A requester whose grant is showing this cycle is not eligible again yet.
  assign elig = req & ~gnt_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    gnt_d   = '0;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    win     = 1'b0;
    case (state_q)
      S_INIT: begin
        wr_d    = 1'b1;
        waddr_d = k_q;
        wdata_d = {5'b0, k_q};
        k_d     = k_q + 3'd1;
        if (k_q == LAST_K) state_d = S_ARB;
      end
      default: begin
        done_d = 1'b1;
        if (elig != '0) begin
          // On a tie the requester not granted last time wins.
          win            = (elig == 2'b11) ? ~last_q : elig[1];
          gnt_d[win]     = 1'b1;
          wr_d           = 1'b1;
          waddr_d        = addr[win];
          wdata_d        = data[win];
          last_d         = win;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      k_q     <= '0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign write_reg  = wr_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign init_done  = done_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboarded bench: requester tasks queue expected writes, a monitor pops
// and checks them on every grant, plus init-sweep and hold-value checks.
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst, req0, req1, gnt0, gnt1, write_reg, init_done;
  logic [2:0] addr0, addr1, write_addr;
  logic [7:0] data0, data1, write_data;

  logic       rst_b, req0_b, req1_b, gnt0_b, gnt1_b, write_reg_b, init_done_b;
  logic [2:0] addr0_b, addr1_b, write_addr_b;
  logic [7:0] data0_b, data1_b, write_data_b;

  int vectors = 0;
  int miscompares = 0;

  wr_t q0[$], q1[$];
  int  order[$];

  reg_write_arbiter #(.INIT_EN(1'b1), .INIT_LAST(6)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .write_reg(write_reg),
    .write_addr(write_addr), .write_data(write_data), .init_done(init_done)
  );

  reg_write_arbiter #(.INIT_EN(1'b0), .INIT_LAST(6)) dut_b (
    .clk(clk), .rst(rst_b),
    .req0(req0_b), .addr0(addr0_b), .data0(data0_b),
    .req1(req1_b), .addr1(addr1_b), .data1(data1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .write_reg(write_reg_b),
    .write_addr(write_addr_b), .write_data(write_data_b), .init_done(init_done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full requester transaction: raise, wait for the grant, keep req high
  // through the grant cycle, drop it, then stay idle for one cycle.
  task automatic issue(input int i, input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    logic g;
    if (i == 0) begin q0.push_back('{a, d}); addr0 = a; data0 = d; req0 = 1'b1; end
    else        begin q1.push_back('{a, d}); addr1 = a; data1 = d; req1 = 1'b1; end
    do begin
      @(negedge clk);
      n++;
      g = (i == 0) ? gnt0 : gnt1;
    end while (!g && n < 40);
    check($sformatf("gnt%0d_timeout", i), 32'(g), 32'd1);
    @(posedge clk); #1;
    if (i == 0) req0 = 1'b0; else req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic driver(input int i, input int count);
    for (int t = 0; t < count; t++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      issue(i, 3'($urandom), 8'($urandom));
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!init_done && n < 30);
    check("init_done_seen", 32'(init_done), 32'd1);
  endtask

  // Monitor: init sweep, grant payloads against the queues, hold behaviour.
  initial begin
    int   init_cnt = 0;
    bit   seen_done = 0;
    logic [2:0] last_a = '0;
    logic [7:0] last_d = '0;
    wr_t  e;
    int   gi;
    forever begin
      @(negedge clk);
      if (!rst) begin
        init_cnt = 0; seen_done = 0; last_a = '0; last_d = '0;
      end else begin
        check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        if (!init_done) begin
          check("init_no_gnt", {30'd0, gnt0, gnt1}, 32'd0);
          if (write_reg) begin
            check("init_addr", 32'(write_addr), 32'(init_cnt[2:0]));
            check("init_data", 32'(write_data), 32'(init_cnt));
            init_cnt++;
          end
        end else begin
          if (!seen_done) begin
            check("init_count", 32'(init_cnt), 32'd7);
            seen_done = 1;
          end
          if (gnt0 || gnt1) begin
            gi = gnt1 ? 1 : 0;
            order.push_back(gi);
            check("gnt_write_en", 32'(write_reg), 32'd1);
            if ((gi == 0 && q0.size() == 0) || (gi == 1 && q1.size() == 0)) begin
              check($sformatf("gnt%0d_unexpected", gi), 32'd1, 32'd0);
            end else begin
              e = (gi == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("gnt%0d_addr", gi), 32'(write_addr), 32'(e.a));
              check($sformatf("gnt%0d_data", gi), 32'(write_data), 32'(e.d));
            end
          end else begin
            check("idle_no_write", 32'(write_reg), 32'd0);
            check("idle_hold_addr", 32'(write_addr), 32'(last_a));
            check("idle_hold_data", 32'(write_data), 32'(last_d));
          end
        end
        if (write_reg) begin last_a = write_addr; last_d = write_data; end
      end
    end
  end

  initial begin
    int exp_ord[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    rst_b = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
    addr0_b = '0; addr1_b = '0; data0_b = '0; data1_b = '0;

    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {17'd0, gnt0, gnt1, write_reg, write_addr, write_data, init_done}, 32'd0);
    rst = 1'b1;

    // Abort INIT after three writes; outputs clear without a clock edge.
    repeat (3) @(posedge clk); #2;
    rst = 1'b0; #1;
    check("abort_outputs", {17'd0, gnt0, gnt1, write_reg, write_addr, write_data, init_done}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    wait_done();
    @(posedge clk); #1;

    // Both requesters held through INIT; requester 0 wins the first tie.
    rst = 1'b0;
    order.delete();
    fork
      issue(0, 3'd3, 8'hA5);
      issue(1, 3'd7, 8'h3C);
    join_none
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    wait_done();
    check("first_arb_gnt", {30'd0, gnt0, gnt1}, 32'b10);
    wait fork;
    @(posedge clk); #1;

    fork
      issue(0, 3'd2, 8'h21);
      issue(1, 3'd2, 8'h22);
    join
    issue(0, 3'd5, 8'h50);
    fork
      issue(0, 3'd1, 8'h01);
      issue(1, 3'd6, 8'h66);
    join
    issue(1, 3'd7, 8'h3C);
    check("order_len", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8 && i < order.size(); i++)
      check($sformatf("order_%0d", i), 32'(order[i]), 32'(exp_ord[i]));

    fork
      driver(0, 25);
      driver(1, 25);
    join
    repeat (3) @(posedge clk); #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    // Instance without the init sweep.
    rst_b = 1'b1; req0_b = 1'b1; addr0_b = 3'd0; data0_b = 8'h11;
    @(negedge clk);
    check("noinit_pre_edge", {29'd0, init_done_b, gnt0_b, write_reg_b}, 32'd0);
    @(negedge clk);
    check("noinit_done_gnt", {28'd0, init_done_b, gnt0_b, gnt1_b, write_reg_b}, 32'b1101);
    check("noinit_addr", 32'(write_addr_b), 32'd0);
    check("noinit_data", 32'(write_data_b), 32'h11);
    @(posedge clk); #1;
    req0_b = 1'b0;
    @(negedge clk);
    check("noinit_single", {29'd0, gnt0_b, gnt1_b, write_reg_b}, 32'd0);
    check("noinit_hold", {21'd0, write_addr_b, write_data_b}, 32'h011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter INIT_EN, default 1, meaning 1 enables the post-reset register initialisation sequence and 0 skips it.
REQ-002 The block SHALL have parameter INIT_LAST, default 6, range 0..7, meaning the highest register address written by the initialisation sequence.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous assert, active-low (0 = reset); released synchronously to clk by the system.
REQ-005 Port: req0  input  1  requester 0 (pipeline writeback) write request, held high until granted.
REQ-006 Port: addr0  input  3  requester 0 target register; stable while req0 high.
REQ-007 Port: data0  input  8  requester 0 write data; stable while req0 high.
REQ-008 Port: req1 / addr1 / data1  input  1 / 3 / 8  requester 1 (load/debug unit), same rules as requester 0.
REQ-009 Port: gnt0, gnt1  output  1 each  one-cycle grant pulse; the write is issued in the same cycle.
REQ-010 Port: write_reg  output  1  register-file write enable.
REQ-011 Port: write_addr  output  3  register-file write address.
REQ-012 Port: write_data  output  8  register-file write data.
REQ-013 Port: init_done  output  1  high once initialisation is complete and arbitration is enabled.

Function
REQ-014 All outputs SHALL be registered; no input SHALL reach an output combinationally.
REQ-015 States SHALL be INIT and ARB; after reset the FSM SHALL enter INIT if INIT_EN=1, otherwise ARB.
REQ-016 INIT: an internal 3-bit counter k SHALL start at 0; each cycle the block SHALL drive write_reg=1, write_addr=k, write_data={5'b0,k}, then increment k.
REQ-017 INIT SHALL run for exactly INIT_LAST+1 cycles (addresses 0..INIT_LAST), then transition to ARB; no address above INIT_LAST is written.
REQ-018 In INIT, gnt0 and gnt1 SHALL remain 0 regardless of requests; pending requests SHALL be held off, not dropped.
REQ-019 init_done SHALL rise in the first ARB cycle and stay high until reset.
REQ-020 ARB: a requester is eligible in cycle t if its req is 1 at edge t and its gnt is not already high in cycle t.
REQ-021 At most one grant SHALL be issued per cycle; gnt0 and gnt1 SHALL never be high together.
REQ-022 With one eligible requester, it SHALL be granted at the next edge.
REQ-023 With both eligible, the requester not granted most recently SHALL win (round-robin); the last-granted pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-024 A grant to requester i at edge t SHALL drive gnt_i=1, write_reg=1, write_addr=addr_i, write_data=data_i in cycle t+1, all for exactly one cycle.
REQ-025 With no eligible requester, write_reg SHALL be 0 and write_addr and write_data SHALL hold their previous values.
REQ-026 Requesters SHALL deassert req in the cycle after gnt; per REQ-020, a req still high in the gnt cycle SHALL NOT cause a duplicate grant.
REQ-027 Writes to the same address from both requesters SHALL be serialised in grant order with no merging; the last write wins.

Reset
REQ-028 While rst=0, all outputs SHALL be 0, k=0, the last-granted pointer SHALL be 1, and the FSM SHALL be in INIT (INIT_EN=1) or ARB (INIT_EN=0), taking effect immediately without waiting for clk.
REQ-029 Reset asserted mid-INIT or mid-grant SHALL abort the operation; after release, INIT SHALL restart from k=0 and no partially issued grant SHALL be repeated.

Verification
REQ-030 Release reset with INIT_EN=1, INIT_LAST=6, no requests -> 7 consecutive writes (addr 0..6, data 0..6), then write_reg=0 and init_done=1 from cycle 8.
REQ-031 Hold req0=1, addr0=3, data0=8'hA5 during INIT -> no gnt during INIT; gnt0 and a write of 8'hA5 to address 3 in the first grant cycle after INIT.
REQ-032 In ARB, raise req0 and req1 simultaneously from reset state -> gnt0 first; if req0 is re-raised, gnt1 next; grants alternate while both keep requesting.
REQ-033 req1 held high for 2 cycles (addr1=7, data1=8'h3C), no other requests -> exactly one gnt1 pulse and one write of 8'h3C to address 7.
REQ-034 Assert rst=0 at INIT cycle 3, release 2 cycles later -> outputs 0 immediately; INIT restarts at address 0 and completes all 7 writes.
REQ-035 INIT_EN=0 -> init_done=1 in the first cycle after reset release; req0 with addr0=0, data0=8'h11 is granted at the next edge.
